counter_arbiter: RTL and testbench
==================================

// Module: counter_arbiter
// PURPOSE
// - Shares one 3-bit up/down counter datapath between N_REQ requesters. Each requester asks for one step (up or down).
// - Grants requests round-robin and sequences the datapath: drives cnt_mode/cnt_din, then captures cnt_dout.
// - Holds the committed count value and returns the result to the granted requester.
// - Sits between the requesting blocks and the counter instance. That instance is external; it has a 1-cycle registered result.
// PARAMETERS
// - N_REQ  4  number of requesters (2..8)
// - WIDTH  3  counter/value width; must equal the datapath width
// - WRAP   1  1: wrap-around at 0/max; 0: saturate (a step past a bound is refused with rsp_err)
// PORTS
// - clk        in   1      clock; all logic on posedge
// - rst        in   1      reset; asynchronous, active-low
// - req_valid  in   N_REQ  request pending, one bit per requester; held until accepted
// - req_dir    in   N_REQ  per-requester step direction: 1=up, 0=down; sampled at handshake
// - req_ready  out  N_REQ  one-hot accept; handshake = req_valid[i] & req_ready[i]
// - rsp_valid  out  N_REQ  one-hot, 1-cycle pulse to the requester whose op completed
// - rsp_err    out  1      qualifies rsp_valid: step refused (saturation), value unchanged
// - rsp_value  out  WIDTH  value after the op; valid with rsp_valid
// - value      out  WIDTH  committed count, always visible
// - busy       out  1      1 whenever state != IDLE
// - cnt_mode   out  1      to datapath: 1=din+1, 0=din-1
// - cnt_din    out  WIDTH  to datapath operand
// - cnt_dout   in   WIDTH  from datapath; registered result, valid 1 cycle after the ISSUE cycle
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, value=0, rr_ptr=0, all outputs 0. An op in flight is aborted with no response.
// - FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE; IDLE -> RESP directly for a refused op.
// - IDLE:
//   - If any req_valid, req_ready is the one-hot round-robin pick, searching from rr_ptr upward with wrap.
//   - req_ready is combinational from req_valid in IDLE only; it is 0 in every other state.
//   - On handshake, latch grant id and dir.
//   - If WRAP=0 and ((dir=1 and value=max) or (dir=0 and value=0)): set err=1, next state RESP.
//   - Otherwise next state ISSUE.
// - ISSUE: cnt_mode=dir, cnt_din=value. The datapath registers the result at the end of this cycle.
// - CAPTURE: value <= cnt_dout.
// - RESP:
//   - rsp_valid[id]=1, rsp_value=value, rsp_err=err.
//   - rr_ptr <= (id+1) mod N_REQ.
//   - Clear err; next state IDLE.
// - Outside ISSUE: cnt_mode=0, cnt_din=value (stable, no spurious intent).
// - Latency:
//   - Normal op: handshake in cycle 0, rsp_valid in cycle 3.
//   - Refused op: rsp_valid in cycle 1.
//   - Throughput: 1 op per 4 cycles (normal), 1 per 2 cycles (refused).
// - Arithmetic is modulo 2^WIDTH. With WRAP=1, max+1 -> 0 and 0-1 -> max, with no error.
// - Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req_valid high and are served in rotation.
//   - No requester waits more than N_REQ-1 grants.
// - Dropping req_valid before req_ready has no effect. req_dir changes before the handshake are ignored.
// - A new handshake is never accepted in RESP. The earliest re-grant is the following IDLE cycle.
// STRUCTURE
// - Package counter_arbiter_pkg:
//   - typedef enum logic [1:0] ctrl_state_e {IDLE, ISSUE, CAPTURE, RESP}
//   - localparam DIR_UP=1'b1, DIR_DOWN=1'b0
// - Sub-module rr_arbiter #(N_REQ): inputs req, ptr; output one-hot gnt.
//   - Purely combinational; rr_ptr is kept in the parent.
// - Bench instantiates the real counter datapath on cnt_mode/cnt_din/cnt_dout.
// TESTING
// - Reset: rst=0 with req_valid=4'b1111
//   -> req_ready=0, rsp_valid=0, value=0, cnt_mode=0, cnt_din=0, busy=0.
// - Single up from 0: req_valid=4'b0001, req_dir[0]=1
//   -> cycle 0 req_ready=4'b0001; cycle 1 cnt_mode=1, cnt_din=0.
//   -> cycle 3 rsp_valid=4'b0001, rsp_value=1, rsp_err=0, value=1.
// - Wrap (WRAP=1): value=7, up -> rsp_value=0, rsp_err=0. Then down from 0 -> rsp_value=7.
// - Saturate (WRAP=0): value=7, up -> rsp_valid at cycle 1, rsp_err=1, rsp_value=7, no ISSUE cycle.
//   - Likewise value=0, down -> rsp_err=1, rsp_value=0.
// - Fairness: all 4 requesters valid, all up, from 0 -> grant order 0,1,2,3,0.
//   -> rsp_value 1,2,3,4,5, one rsp every 4 cycles.
// - Reset mid-op: assert rst in CAPTURE -> no rsp_valid, value=0.
//   -> After release with all valid, first grant goes to requester 0.

Source files
------------

// File: rtl/counter_arbiter_pkg.sv
`default_nettype none
// counter_arbiter_pkg: controller states and step-direction encodings for counter_arbiter.
// Revision 1.0
package counter_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } ctrl_state_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/counter_arbiter_rr.sv
`default_nettype none
// rr_arbiter: combinational one-hot round-robin pick, searching upward from ptr with wrap.
// Revision 1.0
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt
);

   // Walk from the farthest candidate back to ptr so the closest requester wins.
   always_comb begin
      int idx;
      gnt = '0;
      idx = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_arbiter.sv
`default_nettype none
// counter_arbiter: round-robin front end sharing one external up/down counter among N_REQ requesters.
// Revision 1.0
module counter_arbiter
   import counter_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 3,
   parameter int WRAP  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_valid,
   input  logic [N_REQ-1:0] req_dir,
   output logic [N_REQ-1:0] req_ready,
   output logic [N_REQ-1:0] rsp_valid,
   output logic             rsp_err,
   output logic [WIDTH-1:0] rsp_value,
   output logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             cnt_mode,
   output logic [WIDTH-1:0] cnt_din,
   input  logic [WIDTH-1:0] cnt_dout
);

   localparam int               PTR_W   = $clog2(N_REQ);
   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(N_REQ - 1);

   ctrl_state_e      state, state_nxt;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] id;
   logic [PTR_W-1:0] gnt_id;
   logic [N_REQ-1:0] gnt;
   logic             dir;
   logic             err;
   logic             refuse;
   logic             gnt_dir;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

   always_comb begin
      gnt_id = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) gnt_id = PTR_W'(i);
      end
   end

   assign gnt_dir = req_dir[gnt_id];
   // A saturating counter refuses the step in IDLE so no datapath cycle is spent on it.
   assign refuse  = (WRAP == 0) &&
                    (((gnt_dir == DIR_UP)   && (value == MAX_VAL)) ||
                     ((gnt_dir == DIR_DOWN) && (value == '0)));

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      rsp_err   = 1'b0;
      cnt_mode  = 1'b0;
      case (state)
         IDLE: begin
            if (rst) begin
               req_ready = gnt;
               if (|gnt) state_nxt = refuse ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            cnt_mode  = dir;
            state_nxt = CAPTURE;
         end
         CAPTURE: state_nxt = RESP;
         RESP: begin
            rsp_valid[id] = 1'b1;
            rsp_err       = err;
            state_nxt     = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cnt_din   = value;
   assign rsp_value = value;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         value  <= '0;
         rr_ptr <= '0;
         id     <= '0;
         dir    <= DIR_DOWN;
         err    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (|req_ready) begin
                  id  <= gnt_id;
                  dir <= gnt_dir;
                  err <= refuse;
               end
            end
            CAPTURE: value <= cnt_dout;
            RESP: begin
               rr_ptr <= (id == LAST_ID) ? '0 : id + PTR_W'(1);
               err    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// tb_counter_arbiter: randomized scoreboard bench driving a wrapping and a saturating instance side by side.
// Revision 1.0
module tb_counter_arbiter;

   localparam int N = 4;
   localparam int W = 3;

   typedef struct packed {
      logic [1:0]   id;
      logic [W-1:0] val;
      logic         err;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   ph_rate = 100;
   int   ph_dir = 1;
   bit   ph_drop = 1'b0;
   bit   drain_chk = 1'b0;
   int   issue_cyc_g [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Unit 0 wraps, unit 1 saturates.
   for (genvar u = 0; u < 2; u++) begin : g_unit
      logic [N-1:0] req_valid = '0;
      logic [N-1:0] req_dir = '0;
      logic [N-1:0] req_ready;
      logic [N-1:0] rsp_valid;
      logic         rsp_err;
      logic         busy;
      logic         cnt_mode;
      logic [W-1:0] rsp_value;
      logic [W-1:0] value;
      logic [W-1:0] cnt_din;
      logic [W-1:0] cnt_dout;
      exp_t         sbq [$];

      counter_arbiter #(
         .N_REQ (N),
         .WIDTH (W),
         .WRAP  (u == 0 ? 1 : 0)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid),
         .req_dir   (req_dir),
         .req_ready (req_ready),
         .rsp_valid (rsp_valid),
         .rsp_err   (rsp_err),
         .rsp_value (rsp_value),
         .value     (value),
         .busy      (busy),
         .cnt_mode  (cnt_mode),
         .cnt_din   (cnt_din),
         .cnt_dout  (cnt_dout)
      );

      // External counter datapath: one registered step per cycle.
      always @(posedge clk) cnt_dout <= cnt_mode ? cnt_din + 1'b1 : cnt_din - 1'b1;

      initial begin : drv
         logic [N-1:0] pend;
         logic [N-1:0] exp_ready;
         logic [W-1:0] mval;
         logic [W-1:0] upd_val;
         logic         issue_dir;
         int           ptr, idle_from, upd_cyc, win, nv, c;
         exp_t         e;
         pend = '0; mval = '0; upd_val = '0; issue_dir = 1'b0;
         ptr = 0; idle_from = 0; upd_cyc = -1; issue_cyc_g[u] = -1;
         forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
               if (!pend[i] && $urandom_range(0, 99) < ph_rate) pend[i] = 1'b1;
               else if (pend[i] && ph_drop && $urandom_range(0, 99) < 5) pend[i] = 1'b0;
               req_dir[i] = (ph_dir == 0) ? 1'($urandom) : (ph_dir == 1);
            end
            req_valid = pend;
            #1;
            c = cyc;
            if (!rst) begin
               sbq.delete();
               mval = '0; ptr = 0; idle_from = 0; upd_cyc = -1; issue_cyc_g[u] = -1;
               chk($sformatf("u%0d reset_outputs", u),
                   int'({req_ready, rsp_valid, rsp_err, rsp_value, value, busy, cnt_mode, cnt_din}), 0);
            end else begin
               if (c == upd_cyc) mval = upd_val;
               chk($sformatf("u%0d busy", u), int'(busy), int'(c < idle_from));
               chk($sformatf("u%0d cnt_mode", u), int'(cnt_mode),
                   (c == issue_cyc_g[u]) ? int'(issue_dir) : 0);
               chk($sformatf("u%0d cnt_din", u), int'(cnt_din), int'(mval));
               chk($sformatf("u%0d value", u), int'(value), int'(mval));
               exp_ready = '0;
               if (c >= idle_from && pend != '0) begin
                  win = -1;
                  for (int k = 0; k < N; k++) begin
                     if (win < 0 && pend[(ptr + k) % N]) win = (ptr + k) % N;
                  end
                  exp_ready[win] = 1'b1;
                  nv = int'(mval) + (req_dir[win] ? 1 : -1);
                  e.id = 2'(win);
                  e.err = 1'b0;
                  if (nv < 0 || nv > 2**W - 1) begin
                     if (u == 0) nv = (nv + 2**W) % 2**W;
                     else begin
                        e.err = 1'b1;
                        nv = int'(mval);
                     end
                  end
                  e.val = W'(nv);
                  e.due = c + (e.err ? 1 : 3);
                  sbq.push_back(e);
                  if (!e.err) begin
                     upd_cyc = c + 3;
                     upd_val = W'(nv);
                     issue_cyc_g[u] = c + 1;
                     issue_dir = req_dir[win];
                  end
                  idle_from = c + (e.err ? 2 : 4);
                  ptr = (win + 1) % N;
                  pend[win] = 1'b0;
               end
               chk($sformatf("u%0d req_ready", u), int'(req_ready), int'(exp_ready));
            end
         end
      end

      initial begin : mon
         exp_t e;
         forever begin
            @(negedge clk);
            #2;
            if (rst) begin
               if (rsp_valid != '0) begin
                  if (sbq.size() == 0) begin
                     chk($sformatf("u%0d unexpected_rsp", u), int'(rsp_valid), 0);
                  end else begin
                     e = sbq.pop_front();
                     chk($sformatf("u%0d rsp_valid", u), int'(rsp_valid), 1 << e.id);
                     chk($sformatf("u%0d rsp_value", u), int'(rsp_value), int'(e.val));
                     chk($sformatf("u%0d rsp_err", u), int'(rsp_err), int'(e.err));
                     chk($sformatf("u%0d rsp_cycle", u), cyc, e.due);
                  end
               end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                  e = sbq.pop_front();
                  chk($sformatf("u%0d missing_rsp", u), int'(rsp_valid), 1 << e.id);
               end
            end
            if (drain_chk) begin
               chk($sformatf("u%0d drain_pending", u), sbq.size(), 0);
               chk($sformatf("u%0d drain_busy", u), int'(busy), 0);
            end
         end
      end
   end

   initial begin
      bit found;
      rst = 1'b0;
      ph_rate = 100; ph_dir = 1; ph_drop = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      cycles(40);
      ph_dir = 2;
      cycles(40);
      ph_rate = 30; ph_dir = 0; ph_drop = 1'b1;
      cycles(600);
      ph_rate = 100; ph_dir = 1; ph_drop = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         #3;
         if (cyc == issue_cyc_g[0]) found = 1'b1;
      end
      if (!found) begin
         chk("reset_wait_issue", cyc, issue_cyc_g[0]);
      end else begin
         @(posedge clk);
         #1 rst = 1'b0;
         cycles(3);
         rst = 1'b1;
      end
      cycles(40);
      ph_rate = 0;
      cycles(40);
      drain_chk = 1'b1;
      cycles(3);
      drain_chk = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
